// File: rtl/mat_vec_pkg.sv
// Shared definitions for the streaming matrix-vector multiplier: FSM encoding
// and the result-width rule used by the top and its dot-product lanes.
package mat_vec_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COMPUTE = 2'd1,
        ST_DONE    = 2'd2
    } state_e;

    // Wide enough to hold COLS products of two NBITS operands without overflow.
    function automatic int acc_width(input int nbits, input int cols);
        return 2 * nbits + $clog2(cols);
    endfunction

endpackage

// File: rtl/mat_vec_mult_stream_dot_lane.sv
// Combinational dot product of one matrix row with the vector, signed or
// unsigned operands selected at run time.
module dot_lane
    import mat_vec_pkg::*;
#(
    parameter int COLS  = 4,
    parameter int NBITS = 8,
    parameter int ACC   = acc_width(NBITS, COLS)
) (
    input  logic [COLS*NBITS-1:0] row,
    input  logic [COLS*NBITS-1:0] x,
    input  logic                  sign_mode,
    output logic [ACC-1:0]        dot
);

    localparam int PW = 2 * NBITS + 2;

    logic signed [NBITS:0] a_ext;
    logic signed [NBITS:0] x_ext;
    logic signed [PW-1:0]  prod;
    logic signed [ACC-1:0] sum;

    // One extra bit per operand lets a single signed multiplier serve both
    // modes; the final sum is exact modulo 2^ACC and always fits ACC bits.
    always_comb begin
        a_ext = '0;
        x_ext = '0;
        prod  = '0;
        sum   = '0;
        for (int c = 0; c < COLS; c++) begin
            a_ext = {sign_mode & row[c*NBITS+NBITS-1], row[c*NBITS +: NBITS]};
            x_ext = {sign_mode & x[c*NBITS+NBITS-1],   x[c*NBITS +: NBITS]};
            prod  = a_ext * x_ext;
            sum   = sum + ACC'(prod);
        end
        dot = sum;
    end

endmodule

// File: rtl/mat_vec_mult_stream.sv
// Streaming matrix-vector multiplier: accepts M and X in one handshake, then
// computes LANES result rows per cycle and presents Y until it is consumed.
module mat_vec_mult_stream
    import mat_vec_pkg::*;
#(
    parameter  int ROWS  = 4,
    parameter  int COLS  = 4,
    parameter  int NBITS = 8,
    parameter  int LANES = 2,
    localparam int ACC   = acc_width(NBITS, COLS),
    localparam int GRP   = ROWS / LANES
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [ROWS*COLS*NBITS-1:0]  M,
    input  logic [COLS*NBITS-1:0]       X,
    input  logic                        sign_mode,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [ROWS*ACC-1:0]         Y,
    output logic                        busy
);

    localparam int GW = (GRP > 1) ? $clog2(GRP) : 1;
    localparam int RW = COLS * NBITS;

    generate
        if ((LANES < 1) || (ROWS % LANES != 0)) begin : g_bad_lanes
            $error("mat_vec_mult_stream: ROWS must be a positive multiple of LANES");
        end
    endgenerate

    state_e                      state_q, state_d;
    logic [GW-1:0]               grp_q, grp_d;
    logic [ROWS*COLS*NBITS-1:0]  m_q, m_d;
    logic [COLS*NBITS-1:0]       x_q, x_d;
    logic                        sm_q, sm_d;
    logic [ROWS*ACC-1:0]         y_q, y_d;

    logic [LANES-1:0][RW-1:0]    lane_row;
    logic [LANES-1:0][ACC-1:0]   lane_dot;
    int                          base;

    // Rows for the current group are picked out of the held matrix by index.
    always_comb begin
        base = int'(grp_q) * LANES;
        for (int l = 0; l < LANES; l++) begin
            lane_row[l] = m_q[(base + l) * RW +: RW];
        end
    end

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        dot_lane #(
            .COLS  (COLS),
            .NBITS (NBITS),
            .ACC   (ACC)
        ) u_dot_lane (
            .row       (lane_row[l]),
            .x         (x_q),
            .sign_mode (sm_q),
            .dot       (lane_dot[l])
        );
    end

    always_comb begin
        state_d = state_q;
        grp_d   = grp_q;
        m_d     = m_q;
        x_d     = x_q;
        sm_d    = sm_q;
        y_d     = y_q;
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    m_d     = M;
                    x_d     = X;
                    sm_d    = sign_mode;
                    grp_d   = '0;
                    state_d = ST_COMPUTE;
                end
            end
            ST_COMPUTE: begin
                for (int l = 0; l < LANES; l++) begin
                    y_d[(base + l) * ACC +: ACC] = lane_dot[l];
                end
                if (grp_q == GW'(GRP - 1)) begin
                    state_d = ST_DONE;
                end else begin
                    grp_d = grp_q + 1'b1;
                end
            end
            ST_DONE: begin
                // Returning to IDLE first keeps a new accept out of the handshake cycle.
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            grp_q   <= '0;
            y_q     <= '0;
        end else begin
            state_q <= state_d;
            grp_q   <= grp_d;
            y_q     <= y_d;
        end
    end

    // Operand holding registers only matter after an accept, so they need no reset.
    always_ff @(posedge clk) begin
        m_q  <= m_d;
        x_q  <= x_d;
        sm_q <= sm_d;
    end

    assign in_ready  = (state_q == ST_IDLE);
    assign out_valid = (state_q == ST_DONE);
    assign busy      = (state_q != ST_IDLE);
    assign Y         = y_q;

endmodule

// File: tb/tb_mat_vec_mult_stream.sv
// Bench for mat_vec_mult_stream: default 4x4/2-lane instance plus an 8x3
// single-group instance, both checked against an arithmetic reference model.
module tb_mat_vec_mult_stream;

    localparam int AR = 4, AC = 4, BR = 8, BC = 3, NB = 8, ACCW = 18;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset;

    logic                  a_in_valid, a_in_ready, a_sign, a_out_valid, a_out_ready, a_busy;
    logic [AR*AC*NB-1:0]   a_M;
    logic [AC*NB-1:0]      a_X;
    logic [AR*ACCW-1:0]    a_Y;

    logic                  b_in_valid, b_in_ready, b_sign, b_out_valid, b_out_ready, b_busy;
    logic [BR*BC*NB-1:0]   b_M;
    logic [BC*NB-1:0]      b_X;
    logic [BR*ACCW-1:0]    b_Y;

    int vectors     = 0;
    int miscompares = 0;

    mat_vec_mult_stream #(.ROWS(AR), .COLS(AC), .NBITS(NB), .LANES(2)) dut_a (
        .clk(clk), .reset(reset), .in_valid(a_in_valid), .in_ready(a_in_ready),
        .M(a_M), .X(a_X), .sign_mode(a_sign), .out_valid(a_out_valid),
        .out_ready(a_out_ready), .Y(a_Y), .busy(a_busy)
    );

    mat_vec_mult_stream #(.ROWS(BR), .COLS(BC), .NBITS(NB), .LANES(8)) dut_b (
        .clk(clk), .reset(reset), .in_valid(b_in_valid), .in_ready(b_in_ready),
        .M(b_M), .X(b_X), .sign_mode(b_sign), .out_valid(b_out_valid),
        .out_ready(b_out_ready), .Y(b_Y), .busy(b_busy)
    );

    // Reference: plain integer dot products, truncated to the 18-bit result field.
    function automatic logic [BR*ACCW-1:0] model(input int rows, input int cols,
                                                 input logic [BR*BC*NB-1:0] m,
                                                 input logic [BC*NB+7:0] x, input logic s);
        logic [BR*ACCW-1:0] y;
        logic [7:0] mb, xb;
        longint acc, mv, xv;
        y = '0;
        for (int r = 0; r < rows; r++) begin
            acc = 0;
            for (int c = 0; c < cols; c++) begin
                mb = m[(r*cols+c)*8 +: 8];
                xb = x[c*8 +: 8];
                mv = s ? longint'($signed(mb)) : longint'(mb);
                xv = s ? longint'($signed(xb)) : longint'(xb);
                acc += mv * xv;
            end
            y[r*ACCW +: ACCW] = acc[ACCW-1:0];
        end
        return y;
    endfunction

    function automatic logic [AR*ACCW-1:0] model_a(input logic [AR*AC*NB-1:0] m,
                                                   input logic [AC*NB-1:0] x, input logic s);
        logic [BR*ACCW-1:0] full;
        full = model(AR, AC, {64'd0, m}, x, s);
        return full[AR*ACCW-1:0];
    endfunction

    function automatic logic [BR*ACCW-1:0] model_b(input logic [BR*BC*NB-1:0] m,
                                                   input logic [BC*NB-1:0] x, input logic s);
        return model(BR, BC, m, {8'd0, x}, s);
    endfunction

    // Starts a job from IDLE and waits (bounded) for out_valid; lat counts edges after accept.
    task automatic a_run(input logic [AR*AC*NB-1:0] m, input logic [AC*NB-1:0] x,
                         input logic s, input logic scramble, output int lat);
        a_M = m; a_X = x; a_sign = s; a_in_valid = 1'b1;
        @(posedge clk); #1;
        a_in_valid = 1'b0;
        if (scramble) begin
            a_M = {$urandom, $urandom, $urandom, $urandom};
            a_X = $urandom;
            a_sign = ~s;
        end
        lat = 0;
        while (!a_out_valid && lat < 50) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic a_release();
        a_out_ready = 1'b1;
        @(posedge clk); #1;
        a_out_ready = 1'b0;
    endtask

    task automatic b_run(input logic [BR*BC*NB-1:0] m, input logic [BC*NB-1:0] x,
                         input logic s, output int lat);
        b_M = m; b_X = x; b_sign = s; b_in_valid = 1'b1;
        @(posedge clk); #1;
        b_in_valid = 1'b0;
        b_M = {6{$urandom}};
        lat = 0;
        while (!b_out_valid && lat < 50) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        vectors++;
        if ({a_in_ready, a_out_valid, a_busy, a_Y} !== {3'b100, {(AR*ACCW){1'b0}}}) begin
            $display("FAIL reset_a: got rdy=%b vld=%b busy=%b Y=%h, want rdy=1 vld=0 busy=0 Y=0",
                     a_in_ready, a_out_valid, a_busy, a_Y);
            miscompares++;
        end
        vectors++;
        if ({b_in_ready, b_out_valid, b_busy, b_Y} !== {3'b100, {(BR*ACCW){1'b0}}}) begin
            $display("FAIL reset_b: got rdy=%b vld=%b busy=%b Y=%h, want rdy=1 vld=0 busy=0 Y=0",
                     b_in_ready, b_out_valid, b_busy, b_Y);
            miscompares++;
        end
        reset = 1'b0;
    endtask

    task automatic test_identity();
        logic [AR*AC*NB-1:0] m;
        logic [AR*ACCW-1:0] want;
        int lat;
        m = '0;
        for (int r = 0; r < AR; r++) m[(r*AC+r)*8 +: 8] = 8'd1;
        want = {18'd4, 18'd3, 18'd2, 18'd1};
        a_run(m, 32'h04030201, 1'b0, 1'b0, lat);
        vectors++;
        if (lat !== 2) begin
            $display("FAIL identity_latency: got %0d cycles, want 2", lat);
            miscompares++;
        end
        vectors++;
        if (a_Y !== want) begin
            $display("FAIL identity_y: got %h, want %h", a_Y, want);
            miscompares++;
        end
        a_release();
    endtask

    task automatic test_extremes();
        int lat;
        a_run({(AR*AC){8'hFF}}, {AC{8'hFF}}, 1'b0, 1'b0, lat);
        vectors++;
        if (a_Y !== {AR{18'd260100}}) begin
            $display("FAIL ff_unsigned: got %h, want %h", a_Y, {AR{18'd260100}});
            miscompares++;
        end
        a_release();
        a_run({(AR*AC){8'hFF}}, {AC{8'hFF}}, 1'b1, 1'b0, lat);
        vectors++;
        if (a_Y !== {AR{18'd4}}) begin
            $display("FAIL ff_signed: got %h, want %h", a_Y, {AR{18'd4}});
            miscompares++;
        end
        a_release();
        a_run({(AR*AC){8'h80}}, {AC{8'h80}}, 1'b1, 1'b0, lat);
        vectors++;
        if (a_Y !== {AR{18'd65536}}) begin
            $display("FAIL x80_signed: got %h, want %h", a_Y, {AR{18'd65536}});
            miscompares++;
        end
        a_release();
    endtask

    task automatic test_random_a();
        logic [AR*AC*NB-1:0] m;
        logic [AC*NB-1:0] x;
        logic s;
        logic [AR*ACCW-1:0] want;
        int lat;
        for (int i = 0; i < 24; i++) begin
            m = {$urandom, $urandom, $urandom, $urandom};
            x = $urandom;
            s = 1'($urandom_range(0, 1));
            want = model_a(m, x, s);
            a_run(m, x, s, 1'(i % 2), lat);
            vectors++;
            if (lat !== 2 || a_Y !== want) begin
                $display("FAIL random_a[%0d]: got lat=%0d Y=%h, want lat=2 Y=%h", i, lat, a_Y, want);
                miscompares++;
            end
            a_release();
        end
    endtask

    task automatic test_backpressure();
        logic [AR*AC*NB-1:0] m1, m2;
        logic [AC*NB-1:0] x1, x2;
        logic [AR*ACCW-1:0] want1, want2;
        int lat;
        m1 = {$urandom, $urandom, $urandom, $urandom}; x1 = $urandom;
        m2 = {$urandom, $urandom, $urandom, $urandom}; x2 = $urandom;
        want1 = model_a(m1, x1, 1'b1);
        want2 = model_a(m2, x2, 1'b0);
        a_run(m1, x1, 1'b1, 1'b0, lat);
        for (int i = 0; i < 5; i++) begin
            a_in_valid = (i % 2 == 0);
            a_M = {$urandom, $urandom, $urandom, $urandom};
            @(posedge clk); #1;
            vectors++;
            if ({a_out_valid, a_in_ready, a_Y} !== {2'b10, want1}) begin
                $display("FAIL hold[%0d]: got vld=%b rdy=%b Y=%h, want vld=1 rdy=0 Y=%h",
                         i, a_out_valid, a_in_ready, a_Y, want1);
                miscompares++;
            end
        end
        a_M = m2; a_X = x2; a_sign = 1'b0; a_in_valid = 1'b1; a_out_ready = 1'b1;
        @(posedge clk); #1;
        a_out_ready = 1'b0;
        vectors++;
        if ({a_in_ready, a_busy, a_out_valid, a_Y} !== {3'b100, want1}) begin
            $display("FAIL handshake: got rdy=%b busy=%b vld=%b Y=%h, want rdy=1 busy=0 vld=0 Y=%h",
                     a_in_ready, a_busy, a_out_valid, a_Y, want1);
            miscompares++;
        end
        @(posedge clk); #1;
        a_in_valid = 1'b0;
        vectors++;
        if ({a_busy, a_in_ready} !== 2'b10) begin
            $display("FAIL accept_after_handshake: got busy=%b rdy=%b, want busy=1 rdy=0",
                     a_busy, a_in_ready);
            miscompares++;
        end
        lat = 0;
        while (!a_out_valid && lat < 50) begin
            @(posedge clk); #1;
            lat++;
        end
        vectors++;
        if (lat !== 2 || a_Y !== want2) begin
            $display("FAIL next_job: got lat=%0d Y=%h, want lat=2 Y=%h", lat, a_Y, want2);
            miscompares++;
        end
        a_release();
    endtask

    task automatic test_reset_abort();
        logic [AR*AC*NB-1:0] m;
        logic [AC*NB-1:0] x;
        logic [AR*ACCW-1:0] want;
        int lat;
        a_M = {$urandom, $urandom, $urandom, $urandom}; a_X = $urandom; a_sign = 1'b0;
        a_in_valid = 1'b1;
        @(posedge clk); #1;
        a_in_valid = 1'b0;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        vectors++;
        if ({a_out_valid, a_in_ready, a_busy, a_Y} !== {3'b010, {(AR*ACCW){1'b0}}}) begin
            $display("FAIL abort: got vld=%b rdy=%b busy=%b Y=%h, want vld=0 rdy=1 busy=0 Y=0",
                     a_out_valid, a_in_ready, a_busy, a_Y);
            miscompares++;
        end
        m = {$urandom, $urandom, $urandom, $urandom}; x = $urandom;
        want = model_a(m, x, 1'b1);
        a_run(m, x, 1'b1, 1'b0, lat);
        vectors++;
        if (lat !== 2 || a_Y !== want) begin
            $display("FAIL after_abort: got lat=%0d Y=%h, want lat=2 Y=%h", lat, a_Y, want);
            miscompares++;
        end
        a_release();
    endtask

    task automatic test_back_to_back();
        logic [AR*AC*NB-1:0] m;
        logic [AC*NB-1:0] x;
        logic [AR*ACCW-1:0] want;
        int hits[$];
        m = {$urandom, $urandom, $urandom, $urandom}; x = $urandom;
        want = model_a(m, x, 1'b1);
        a_M = m; a_X = x; a_sign = 1'b1;
        a_in_valid = 1'b1; a_out_ready = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            @(posedge clk); #1;
            if (a_out_valid) begin
                hits.push_back(k);
                vectors++;
                if (a_Y !== want) begin
                    $display("FAIL b2b_y[%0d]: got %h, want %h", k, a_Y, want);
                    miscompares++;
                end
            end
        end
        a_in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        a_out_ready = 1'b0;
        vectors++;
        if (hits.size() !== 3 || hits[0] !== 3 || hits[1] !== 7 || hits[2] !== 11) begin
            $display("FAIL b2b_period: got %0d results first at cycle %0d, want 3 results at 3,7,11",
                     hits.size(), (hits.size() > 0) ? hits[0] : -1);
            miscompares++;
        end
    endtask

    task automatic test_single_group();
        logic [BR*BC*NB-1:0] m;
        logic [BC*NB-1:0] x;
        logic s;
        logic [BR*ACCW-1:0] want;
        int lat;
        for (int i = 0; i < 16; i++) begin
            m = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
            if (i == 0) m = {(BR*BC){8'h80}};
            x = 24'($urandom);
            if (i == 0) x = {BC{8'h80}};
            s = (i == 0) ? 1'b1 : 1'(i % 2);
            want = model_b(m, x, s);
            b_run(m, x, s, lat);
            vectors++;
            if (lat !== 1 || b_Y !== want) begin
                $display("FAIL single_group[%0d]: got lat=%0d Y=%h, want lat=1 Y=%h", i, lat, b_Y, want);
                miscompares++;
            end
            b_out_ready = 1'b1;
            @(posedge clk); #1;
            b_out_ready = 1'b0;
        end
    endtask

    initial begin
        reset = 1'b1;
        a_in_valid = 1'b0; a_out_ready = 1'b0; a_sign = 1'b0; a_M = '0; a_X = '0;
        b_in_valid = 1'b0; b_out_ready = 1'b0; b_sign = 1'b0; b_M = '0; b_X = '0;
        test_reset();
        test_identity();
        test_extremes();
        test_random_a();
        test_backpressure();
        test_reset_abort();
        test_back_to_back();
        test_single_group();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $fatal(1, "timeout");
    end

endmodule
